// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared opcodes, FSM state encoding, NOP word and helpers
// for the pipeline hazard/flush controller and its source-register decoder.
package pipeline_ctrl_pkg;

    // Opcodes relevant to source-register decode
    localparam logic [5:0] OpRType = 6'd0;
    localparam logic [5:0] OpLw    = 6'd35;
    localparam logic [5:0] OpSw    = 6'd43;
    localparam logic [5:0] OpBeq   = 6'd4;
    localparam logic [5:0] OpJ     = 6'd2;

    // Word loaded into the fetch latch when it is flushed
    localparam logic [31:0] NopWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StStall   = 2'd1,
        StFlush   = 2'd2,
        StIllegal = 2'd3
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ir_write;
        logic dx_bubble;
        logic if_flush;
    } ctrl_t;

    // Bubble counter reload: the entry cycle is itself the first bubble, so the
    // counter holds the bubbles still to come after it.
    function automatic logic [1:0] bub_reload(input int unsigned n);
        return (n > 1) ? 2'(n - 1) : 2'd0;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_src_decode.sv
// src_decode: combinational source-register decode of the decode-stage IR.
// Ports:
//   ir_i     - instruction in decode
//   uses_rs  - instruction reads rs (IR[25:21])
//   uses_rt  - instruction reads rt (IR[20:16])
//   rs, rt   - the two source register fields
module src_decode
    import pipeline_ctrl_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic        uses_rs,
    output logic        uses_rt,
    output logic [4:0]  rs,
    output logic [4:0]  rt
);

    logic [5:0] opcode;
    logic       unused_ir;

    assign opcode    = ir_i[31:26];
    assign rs        = ir_i[25:21];
    assign rt        = ir_i[20:16];
    assign unused_ir = ^ir_i[15:0];

    always_comb begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        case (opcode)
            OpRType, OpSw, OpBeq: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OpLw: begin
                uses_rs = 1'b1;
            end
            OpJ: begin
                // jump reads no registers
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: load-use stall and taken-branch flush controller.
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   IR                  - instruction in decode
//   DX_RD, DX_lwFlag    - destination / lw flag of the instruction in DX
//   ex_taken            - branch taken or jump resolved in execute
//   pc_write, ir_write  - PC / decode-latch write enables
//   dx_bubble, if_flush - insert NOP into DX / fetch latch
//   state_o             - current FSM state
//   stall_cnt, flush_cnt- saturating event counters
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_BUBBLES  = 1,
    parameter int unsigned FLUSH_BUBBLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IR,
    input  logic [4:0]  DX_RD,
    input  logic        DX_lwFlag,
    input  logic        ex_taken,
    output logic        pc_write,
    output logic        ir_write,
    output logic        dx_bubble,
    output logic        if_flush,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [1:0] LoadInit  = bub_reload(LOAD_BUBBLES);
    localparam logic [1:0] FlushInit = bub_reload(FLUSH_BUBBLES);

    localparam ctrl_t CtrlRun   = '{pc_write: 1'b1, ir_write: 1'b1, dx_bubble: 1'b0, if_flush: 1'b0};
    localparam ctrl_t CtrlStall = '{pc_write: 1'b0, ir_write: 1'b0, dx_bubble: 1'b1, if_flush: 1'b0};
    localparam ctrl_t CtrlTaken = '{pc_write: 1'b1, ir_write: 1'b1, dx_bubble: 1'b1, if_flush: 1'b1};
    localparam ctrl_t CtrlFlush = '{pc_write: 1'b1, ir_write: 1'b1, dx_bubble: 1'b1, if_flush: 1'b0};
    localparam ctrl_t CtrlReset = '{pc_write: 1'b0, ir_write: 1'b0, dx_bubble: 1'b1, if_flush: 1'b1};

    state_e      state_q, state_d;
    logic [1:0]  bub_cnt_q, bub_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    ctrl_t       ctrl;

    logic       uses_rs, uses_rt;
    logic [4:0] rs, rt;
    logic       hazard;

    src_decode u_src_decode (
        .ir_i    (IR),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt),
        .rs      (rs),
        .rt      (rt)
    );

    // Load-use hazard; $0 as destination never hazards
    assign hazard = DX_lwFlag && (DX_RD != 5'd0) &&
                    ((uses_rs && (rs == DX_RD)) || (uses_rt && (rt == DX_RD)));

    always_comb begin
        state_d   = state_q;
        bub_cnt_d = bub_cnt_q;
        ctrl      = CtrlRun;

        if (ex_taken) begin
            ctrl = CtrlTaken;
            if (FLUSH_BUBBLES > 1) begin
                state_d   = StFlush;
                bub_cnt_d = FlushInit;
            end else begin
                state_d   = StRun;
                bub_cnt_d = 2'd0;
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    if (hazard) begin
                        ctrl = CtrlStall;
                        if (LOAD_BUBBLES > 1) begin
                            state_d   = StStall;
                            bub_cnt_d = LoadInit;
                        end else begin
                            state_d   = StRun;
                            bub_cnt_d = 2'd0;
                        end
                    end
                end
                StStall: begin
                    ctrl      = CtrlStall;
                    bub_cnt_d = bub_cnt_q - 2'd1;
                    // <= 1 also drains a corrupted zero count instead of wrapping
                    if (bub_cnt_q <= 2'd1) begin
                        state_d   = StRun;
                        bub_cnt_d = 2'd0;
                    end
                end
                StFlush: begin
                    ctrl      = CtrlFlush;
                    bub_cnt_d = bub_cnt_q - 2'd1;
                    if (bub_cnt_q <= 2'd1) begin
                        state_d   = StRun;
                        bub_cnt_d = 2'd0;
                    end
                end
                default: begin
                    // illegal encoding: behave as RUN for one cycle, then RUN
                    ctrl      = CtrlRun;
                    state_d   = StRun;
                    bub_cnt_d = 2'd0;
                end
            endcase
        end

        if (!rst) begin
            ctrl = CtrlReset;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!ctrl.pc_write && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (ex_taken && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StRun;
            bub_cnt_q   <= 2'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            bub_cnt_q   <= bub_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_write  = ctrl.pc_write;
    assign ir_write  = ctrl.ir_write;
    assign dx_bubble = ctrl.dx_bubble;
    assign if_flush  = ctrl.if_flush;
    assign state_o   = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (defaults, and LOAD_BUBBLES=3 with
// FLUSH_BUBBLES=1) share stimulus and are checked every cycle against a
// remaining-bubble model, plus directed literal checks.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] ir;
    logic [4:0]  dx_rd;
    logic        dx_lw;
    logic        ex;

    logic [1:0]  pcw, irw, bub, flu;
    logic [1:0]  st  [2];
    logic [15:0] scnt[2];
    logic [15:0] fcnt[2];

    int vectors;
    int miscompares;

    // model state: bubbles still owed after the current cycle's entry
    int  stall_left[2];
    int  flush_left[2];
    int  m_scnt[2];
    int  m_fcnt[2];
    bit  model_valid;

    localparam logic [31:0] ADD  = {6'd0, 5'd5, 5'd6, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] SW7  = {6'd43, 5'd2, 5'd7, 16'd0};
    localparam logic [31:0] ADD0 = {6'd0, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20};

    pipeline_ctrl u0 (
        .clk(clk), .rst(rst), .IR(ir), .DX_RD(dx_rd), .DX_lwFlag(dx_lw), .ex_taken(ex),
        .pc_write(pcw[0]), .ir_write(irw[0]), .dx_bubble(bub[0]), .if_flush(flu[0]),
        .state_o(st[0]), .stall_cnt(scnt[0]), .flush_cnt(fcnt[0])
    );

    pipeline_ctrl #(.LOAD_BUBBLES(3), .FLUSH_BUBBLES(1)) u1 (
        .clk(clk), .rst(rst), .IR(ir), .DX_RD(dx_rd), .DX_lwFlag(dx_lw), .ex_taken(ex),
        .pc_write(pcw[1]), .ir_write(irw[1]), .dx_bubble(bub[1]), .if_flush(flu[1]),
        .state_o(st[1]), .stall_cnt(scnt[1]), .flush_cnt(fcnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lb(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int fb(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // hazard straight from the source-read rules
    function automatic bit hz();
        int  op;
        bit  r_rs, r_rt;
        op   = int'(ir[31:26]);
        r_rs = (op == 0) || (op == 35) || (op == 43) || (op == 4);
        r_rt = (op == 0) || (op == 43) || (op == 4);
        return dx_lw && (dx_rd != 0) &&
               ((r_rs && ir[25:21] == dx_rd) || (r_rt && ir[20:16] == dx_rd));
    endfunction

    function automatic bit m_pc(input int i);
        if (!rst) return 1'b0;
        if (ex) return 1'b1;
        if (flush_left[i] > 0) return 1'b1;
        if (stall_left[i] > 0) return 1'b0;
        return !hz();
    endfunction

    function automatic bit m_bub(input int i);
        if (!rst || ex) return 1'b1;
        if (flush_left[i] > 0 || stall_left[i] > 0) return 1'b1;
        return hz();
    endfunction

    function automatic bit m_flu();
        return !rst || ex;
    endfunction

    function automatic int m_state(input int i);
        if (flush_left[i] > 0) return 2;
        if (stall_left[i] > 0) return 1;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model advances on the same edge as the DUT
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                stall_left[i] <= 0;
                flush_left[i] <= 0;
                m_scnt[i]     <= 0;
                m_fcnt[i]     <= 0;
            end else begin
                if (ex) begin
                    flush_left[i] <= fb(i) - 1;
                    stall_left[i] <= 0;
                end else if (flush_left[i] > 0) begin
                    flush_left[i] <= flush_left[i] - 1;
                end else if (stall_left[i] > 0) begin
                    stall_left[i] <= stall_left[i] - 1;
                end else if (hz()) begin
                    stall_left[i] <= lb(i) - 1;
                end
                if (!m_pc(i) && m_scnt[i] < 65535) m_scnt[i] <= m_scnt[i] + 1;
                if (ex && m_fcnt[i] < 65535) m_fcnt[i] <= m_fcnt[i] + 1;
            end
        end
        model_valid <= 1'b1;
    end

    // per-cycle compare, inputs stable since the falling edge
    always @(negedge clk) begin
        #2;
        if (model_valid) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d.pc_write", i), 32'(pcw[i]), 32'(m_pc(i)));
                chk($sformatf("u%0d.ir_write", i), 32'(irw[i]), 32'(m_pc(i)));
                chk($sformatf("u%0d.dx_bubble", i), 32'(bub[i]), 32'(m_bub(i)));
                chk($sformatf("u%0d.if_flush", i), 32'(flu[i]), 32'(m_flu()));
                chk($sformatf("u%0d.state_o", i), 32'(st[i]), 32'(m_state(i)));
                chk($sformatf("u%0d.stall_cnt", i), 32'(scnt[i]), 32'(m_scnt[i]));
                chk($sformatf("u%0d.flush_cnt", i), 32'(fcnt[i]), 32'(m_fcnt[i]));
            end
        end
    end

    task automatic step(input logic [31:0] i_ir, input logic [4:0] i_rd, input logic i_lw,
                        input logic i_ex, input logic i_rst);
        @(negedge clk);
        ir    = i_ir;
        dx_rd = i_rd;
        dx_lw = i_lw;
        ex    = i_ex;
        rst   = i_rst;
    endtask

    task automatic idle(input logic i_rst);
        step(ADD, 5'd5, 1'b0, 1'b0, i_rst);
    endtask

    initial begin
        logic [5:0] op;
        vectors     = 0;
        miscompares = 0;
        model_valid = 1'b0;
        rst   = 1'b0;
        ir    = ADD;
        dx_rd = 5'd5;
        dx_lw = 1'b0;
        ex    = 1'b0;

        // reset outputs and state
        idle(1'b0);
        idle(1'b0);
        #3;
        chk("rst.pc_write", 32'(pcw[0]), 32'd0);
        chk("rst.dx_bubble", 32'(bub[0]), 32'd1);
        chk("rst.if_flush", 32'(flu[0]), 32'd1);
        chk("rst.state", 32'(st[0]), 32'd0);
        chk("rst.stall_cnt", 32'(scnt[0]), 32'd0);
        idle(1'b1);
        #3;
        chk("run.pc_write", 32'(pcw[0]), 32'd1);
        chk("run.dx_bubble", 32'(bub[0]), 32'd0);

        // single load-use bubble with defaults
        step(ADD, 5'd5, 1'b1, 1'b0, 1'b1);
        #3;
        chk("lu1.pc_write", 32'(pcw[0]), 32'd0);
        chk("lu1.dx_bubble", 32'(bub[0]), 32'd1);
        idle(1'b1);
        #3;
        chk("lu1.after_pc", 32'(pcw[0]), 32'd1);
        chk("lu1.after_state", 32'(st[0]), 32'd0);
        chk("lu1.stall_cnt", 32'(scnt[0]), 32'd1);

        // lw to $0 never stalls
        step(ADD0, 5'd0, 1'b1, 1'b0, 1'b1);
        #3;
        chk("r0.pc_write", 32'(pcw[0]), 32'd1);

        idle(1'b0);
        idle(1'b1);

        // three bubbles on an rt match
        step(SW7, 5'd7, 1'b1, 1'b0, 1'b1);
        #3;
        chk("lu3.c0.state", 32'(st[1]), 32'd0);
        chk("lu3.c0.pc", 32'(pcw[1]), 32'd0);
        idle(1'b1);
        #3;
        chk("lu3.c1.state", 32'(st[1]), 32'd1);
        chk("lu3.c1.pc", 32'(pcw[1]), 32'd0);
        idle(1'b1);
        #3;
        chk("lu3.c2.state", 32'(st[1]), 32'd1);
        chk("lu3.c2.pc", 32'(pcw[1]), 32'd0);
        idle(1'b1);
        #3;
        chk("lu3.c3.state", 32'(st[1]), 32'd0);
        chk("lu3.c3.pc", 32'(pcw[1]), 32'd1);
        chk("lu3.stall_cnt", 32'(scnt[1]), 32'd3);

        idle(1'b0);
        idle(1'b1);

        // taken branch beats a concurrent hazard
        step(ADD, 5'd5, 1'b1, 1'b1, 1'b1);
        #3;
        chk("br.if_flush", 32'(flu[0]), 32'd1);
        chk("br.pc_write", 32'(pcw[0]), 32'd1);
        chk("br.dx_bubble", 32'(bub[0]), 32'd1);
        idle(1'b1);
        #3;
        chk("br.flush_state", 32'(st[0]), 32'd2);
        chk("br.flush_bubble", 32'(bub[0]), 32'd1);
        chk("br.flush_if", 32'(flu[0]), 32'd0);
        idle(1'b1);
        #3;
        chk("br.run_state", 32'(st[0]), 32'd0);
        chk("br.run_bubble", 32'(bub[0]), 32'd0);
        chk("br.flush_cnt", 32'(fcnt[0]), 32'd1);
        chk("br.stall_cnt", 32'(scnt[0]), 32'd0);

        idle(1'b0);
        idle(1'b1);

        // reset in the second STALL cycle abandons the rest
        step(ADD, 5'd5, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        #3;
        chk("rs.stall1", 32'(st[1]), 32'd1);
        idle(1'b0);
        #3;
        chk("rs.stall2", 32'(st[1]), 32'd1);
        idle(1'b1);
        #3;
        chk("rs.rel_state", 32'(st[1]), 32'd0);
        chk("rs.rel_pc", 32'(pcw[1]), 32'd1);
        chk("rs.rel_stall_cnt", 32'(scnt[1]), 32'd0);
        idle(1'b1);
        #3;
        chk("rs.next_bubble", 32'(bub[1]), 32'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 6))
                0: op = 6'd0;
                1: op = 6'd35;
                2: op = 6'd43;
                3: op = 6'd4;
                4: op = 6'd2;
                5: op = 6'd8;
                default: op = 6'($urandom);
            endcase
            step({op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)},
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) != 0));
        end

        // stall counter saturation
        idle(1'b0);
        for (int n = 0; n < 70000; n++) begin
            step(ADD, 5'd5, 1'b1, 1'b0, 1'b1);
        end
        #3;
        chk("sat.u0", 32'(scnt[0]), 32'hFFFF);
        chk("sat.u1", 32'(scnt[1]), 32'hFFFF);
        idle(1'b1);
        @(negedge clk);
        #4;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
